// File: rtl/console_arbiter.sv
// console_arbiter: round-robin sharing of one Wishbone console slave among N_MASTERS requesters.
// Optional stalled-strobe timeout enabled by defining CONSOLE_ARB_TIMEOUT_EN.
module console_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int MAX_BEATS      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_MASTERS-1:0]      req_cyc,
    input  logic [N_MASTERS-1:0]      req_stb,
    input  logic [N_MASTERS-1:0]      req_we,
    input  logic [32*N_MASTERS-1:0]   req_dat,
    output logic [N_MASTERS-1:0]      req_ack,
    output logic [N_MASTERS-1:0]      req_err,
    output logic [31:0]               req_rdat,
    output logic                      s_cyc,
    output logic                      s_stb,
    output logic                      s_we,
    output logic [31:0]               s_dat,
    input  logic                      s_ack,
    input  logic [31:0]               s_rdat
);
    localparam int W = $clog2(N_MASTERS);
    localparam logic [N_MASTERS-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
    state_t state, state_nxt;

    logic [W-1:0] grant, last, pick;
    logic [7:0]   beat_cnt;
    logic         busy, beat, cap_hit, timeout, found;
    int           idx;

    assign busy     = state == BUSY;
    assign beat     = busy & s_ack & s_stb;
    assign cap_hit  = beat && (beat_cnt == 8'(MAX_BEATS - 1));
    assign req_rdat = s_rdat;

    // Scan starts one past the previous owner and wraps modulo N explicitly.
    always_comb begin
        pick  = last;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            idx = (int'(last) + i) % N_MASTERS;
            if (!found && req_cyc[idx]) begin
                pick  = W'(idx);
                found = 1'b1;
            end
        end
    end

`ifdef CONSOLE_ARB_TIMEOUT_EN
    logic [15:0] stall_cnt;
    assign timeout = busy && s_stb && !s_ack && (stall_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign req_err = timeout ? ONE << grant : '0;
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            stall_cnt <= '0;
        else
            stall_cnt <= (busy && s_stb && !s_ack && !timeout) ? stall_cnt + 16'd1 : '0;
`else
    assign timeout = 1'b0;
    assign req_err = '0;
`endif

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= IDLE;
            grant    <= '0;
            last     <= W'(N_MASTERS - 1);
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |req_cyc)
                grant <= pick;
            if (busy && state_nxt == RELEASE)
                last <= grant;
            beat_cnt <= (state == RELEASE) ? '0 : beat ? beat_cnt + 8'd1 : beat_cnt;
        end

    always_comb
        state_nxt = (state == IDLE) ? (|req_cyc ? BUSY : IDLE) :
                    busy ? ((!req_cyc[grant] || cap_hit || timeout) ? RELEASE : BUSY) :
                    IDLE;

    always_comb begin
        s_cyc   = busy;
        s_stb   = busy & req_stb[grant];
        s_we    = busy & req_we[grant];
        s_dat   = busy ? req_dat[32*grant +: 32] : '0;
        req_ack = (busy & s_ack & req_stb[grant]) ? ONE << grant : '0;
    end
endmodule

// File: tb/tb_console_arbiter.sv
// tb_console_arbiter: table-driven and scoreboarded checks of console_arbiter (N=2, MAX_BEATS=4, TIMEOUT=16).
module tb_console_arbiter;
    logic        clk = 0, rst = 0, s_ack = 0;
    logic [1:0]  cyc = 0, stb = 0, ack, err;
    logic [63:0] dat = 0;
    logic [31:0] rdat, s_rdat = 32'hC0DE1234, s_dat;
    logic        s_cyc, s_stb, s_we;
    int          checks = 0, errors = 0;

    console_arbiter #(.N_MASTERS(2), .MAX_BEATS(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req_cyc(cyc), .req_stb(stb), .req_we(stb), .req_dat(dat),
        .req_ack(ack), .req_err(err), .req_rdat(rdat), .s_cyc(s_cyc), .s_stb(s_stb),
        .s_we(s_we), .s_dat(s_dat), .s_ack(s_ack), .s_rdat(s_rdat));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cyc, stb; logic [31:0] d1; logic ack;
        logic e_cyc, e_stb; logic [31:0] e_dat; logic [1:0] e_ack;
    } vec_t;
    typedef struct { int id; logic [31:0] d; } beat_t;

    vec_t  tbl[$], sb[$], v;
    beat_t exp_q[$], b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] c, input logic [31:0] d1, input logic a,
                       input logic ec, input logic es, input logic [31:0] ed, input logic [1:0] ea);
        tbl.push_back('{c, c, d1, a, ec, es, ed, ea});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rem0, rem1, sent0, sent1, low, owners, cyc_n;
        logic prev;
        // reset state and async reset mid-burst
        @(negedge clk);
        chk("rst_s_cyc", s_cyc, 0); chk("rst_s_stb", s_stb, 0); chk("rst_ack", ack, 0);
        chk("rst_err", err, 0); chk("rst_s_dat", s_dat, 0); chk("rdat_pass", rdat, 32'hC0DE1234);
        @(posedge clk); #1 rst = 1; cyc = 2'b01; stb = 2'b01; dat[31:0] = 32'h11; s_ack = 1;
        @(negedge clk); chk("lat_idle", s_cyc, 0);
        @(negedge clk); chk("lat_busy", s_cyc, 1); chk("m0_ack", ack, 2'b01);
        #2 rst = 0; #1;
        chk("mid_rst_cyc", s_cyc, 0); chk("mid_rst_stb", s_stb, 0); chk("mid_rst_ack", ack, 0);
        @(posedge clk); #1 rst = 1; cyc = 2'b10; stb = 2'b10; dat = {32'h22, 32'h11}; s_ack = 0;
        @(negedge clk); chk("post_rst_idle", s_cyc, 0);
        @(negedge clk); chk("post_rst_cyc", s_cyc, 1); chk("post_rst_dat", s_dat, 32'h22);
        @(posedge clk); #1 cyc = 0; stb = 0;
        repeat (2) @(posedge clk);
        // single write, contention, isolation, alternation
        add(2'b10, 32'h41, 0, 0, 0, 0, 2'b00);
        add(2'b10, 32'h41, 1, 1, 1, 32'h41, 2'b10);
        add(2'b00, 32'h41, 0, 1, 0, 32'h41, 2'b00);
        add(2'b00, 32'h41, 0, 0, 0, 0, 2'b00);
        add(2'b00, 32'h41, 0, 0, 0, 0, 2'b00);
        add(2'b11, 32'h55, 0, 0, 0, 0, 2'b00);
        add(2'b11, 32'h55, 1, 1, 1, 32'h30, 2'b01);
        add(2'b10, 32'h55, 1, 1, 0, 32'h30, 2'b00);
        add(2'b10, 32'h55, 1, 0, 0, 0, 2'b00);
        add(2'b10, 32'h55, 0, 0, 0, 0, 2'b00);
        add(2'b10, 32'h55, 1, 1, 1, 32'h55, 2'b10);
        add(2'b00, 32'h55, 0, 1, 0, 32'h55, 2'b00);
        add(2'b00, 32'h55, 0, 0, 0, 0, 2'b00);
        add(2'b00, 32'h55, 0, 0, 0, 0, 2'b00);
        add(2'b11, 32'h55, 0, 0, 0, 0, 2'b00);
        add(2'b11, 32'h55, 1, 1, 1, 32'h30, 2'b01);
        add(2'b00, 32'h55, 0, 1, 0, 32'h30, 2'b00);
        add(2'b00, 32'h55, 0, 0, 0, 0, 2'b00);
        add(2'b00, 32'h55, 0, 0, 0, 0, 2'b00);
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            cyc = tbl[i].cyc; stb = tbl[i].stb; s_ack = tbl[i].ack;
            dat = {tbl[i].d1, 32'h30};
            sb.push_back(tbl[i]);
            @(negedge clk);
            v = sb.pop_front();
            chk($sformatf("v%0d_cyc", i), s_cyc, v.e_cyc);
            chk($sformatf("v%0d_stb", i), s_stb, v.e_stb);
            chk($sformatf("v%0d_we", i), s_we, v.e_stb);
            chk($sformatf("v%0d_dat", i), s_dat, v.e_dat);
            chk($sformatf("v%0d_ack", i), ack, v.e_ack);
        end
        // burst cap: master0 sends 6, master1 sends 1 after master0 starts
        for (int k = 0; k < 4; k++) exp_q.push_back('{0, 32'h60 + k});
        exp_q.push_back('{1, 32'h70});
        for (int k = 4; k < 6; k++) exp_q.push_back('{0, 32'h60 + k});
        rem0 = 6; rem1 = 1; sent0 = 0; sent1 = 0; low = 0; owners = 0; prev = 0; cyc_n = 0;
        while ((rem0 > 0 || rem1 > 0) && cyc_n < 80) begin
            cyc_n++;
            @(posedge clk); #1;
            cyc = {rem1 > 0 && sent0 >= 1, rem0 > 0}; stb = cyc; s_ack = 1;
            dat = {32'h70 + 32'(sent1), 32'h60 + 32'(sent0)};
            @(negedge clk);
            if (s_cyc && !prev) begin
                if (owners > 0) chk("owner_gap", low, 2);
                owners++;
            end
            low  = s_cyc ? 0 : low + 1;
            prev = s_cyc;
            if (ack != 0) begin
                b = exp_q.pop_front();
                chk("burst_id", ack, b.id == 0 ? 2'b01 : 2'b10);
                chk("burst_dat", s_dat, b.d);
                if (ack[0]) begin rem0--; sent0++; end
                if (ack[1]) begin rem1--; sent1++; end
            end
        end
        chk("burst_done", exp_q.size(), 0);
        @(posedge clk); #1 cyc = 0; stb = 0; s_ack = 0;
        repeat (2) @(posedge clk);
        // stalled slave: timeout releases to master1, otherwise grant is held
        for (int i = 0; i < 22; i++) begin
            logic e_c; logic [31:0] e_d; logic [1:0] e_e;
            @(posedge clk); #1;
            cyc = {i >= 2, 1'b1}; stb = cyc; s_ack = 0; dat = {32'h90, 32'h80};
`ifdef CONSOLE_ARB_TIMEOUT_EN
            e_c = (i >= 1 && i <= 16) || i >= 19;
            e_d = (i >= 1 && i <= 16) ? 32'h80 : i >= 19 ? 32'h90 : 32'h0;
            e_e = i == 16 ? 2'b01 : 2'b00;
`else
            e_c = i >= 1;
            e_d = i >= 1 ? 32'h80 : 32'h0;
            e_e = 2'b00;
`endif
            @(negedge clk);
            chk($sformatf("to%0d_cyc", i), s_cyc, e_c);
            chk($sformatf("to%0d_dat", i), s_dat, e_d);
            chk($sformatf("to%0d_err", i), err, e_e);
            chk($sformatf("to%0d_ack", i), ack, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
